// File: rtl/tmr_pkg.sv
// Shared types and constants for the TMR health tracker: core state encoding,
// core indices and the per-voter fault-bit layout.
package tmr_pkg;

    typedef enum logic [1:0] {
        HEALTHY = 2'b00,
        SUSPECT = 2'b01,
        FAULTY  = 2'b10
    } core_state_t;

    localparam int N_CORES = 3;

    // A core index is also that core's bit offset inside a voter's {A,B,C} group.
    localparam int CORE_A = 2;
    localparam int CORE_B = 1;
    localparam int CORE_C = 0;

    localparam int FAULT_BITS_PER_VOTER = 3;

endpackage

// File: rtl/tmr_core_health.sv
// Per-core health tracking: saturating leaky-bucket fault counter plus the
// HEALTHY/SUSPECT/FAULTY state machine driven by the registered count.
module tmr_core_health
    import tmr_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int N_W            = 3,
    parameter int SUSPECT_THRESH = 16,
    parameter int FAULT_THRESH   = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_W-1:0]   n_inc,
    input  logic             decay_tick,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output core_state_t      state,
    output logic             enter_faulty
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] SUS_LVL  = CNT_W'(SUSPECT_THRESH);
    localparam logic [CNT_W-1:0] FLT_LVL  = CNT_W'(FAULT_THRESH);

    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] count_next;
    core_state_t      state_next;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sum        = {1'b0, count} + (CNT_W+1)'(n_inc);
        count_next = count;
        if (clear)
            count_next = '0;
        else if (n_inc != '0)
            count_next = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
        else if (decay_tick && count != '0)
            count_next = count - 1'b1;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            HEALTHY: begin
                if (count >= FLT_LVL)      state_next = FAULTY;
                else if (count >= SUS_LVL) state_next = SUSPECT;
            end
            SUSPECT: begin
                if (count >= FLT_LVL)      state_next = FAULTY;
                else if (count == '0)      state_next = HEALTHY;
            end
            FAULTY:  state_next = FAULTY;
            default: state_next = HEALTHY;
        endcase
        if (clear)
            state_next = HEALTHY;
    end

    assign enter_faulty = (state_next == FAULTY) && (state != FAULTY);

    // NOTE: state registers use non-blocking assignments and take the async reset; combinational next-state stays in always_comb.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            state <= HEALTHY;
        end else begin
            count <= count_next;
            state <= state_next;
        end
    end

endmodule

// File: rtl/tmr_health_tracker.sv
// Aggregates masked voter fault/disagree flags, tracks per-core health, and
// produces the fault interrupt and TMR/system status for the CSR block.
module tmr_health_tracker
    import tmr_pkg::*;
#(
    parameter int N_VOTERS       = 5,
    parameter int CNT_W          = 16,
    parameter int SUSPECT_THRESH = 16,
    parameter int FAULT_THRESH   = 100,
    parameter int DECAY_PERIOD   = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N_VOTERS-1:0]                  voter_disagree,
    input  logic [FAULT_BITS_PER_VOTER*N_VOTERS-1:0] voter_faults,
    input  logic [N_VOTERS-1:0]                  voter_mask,
    input  logic                                 clear,
    input  logic                                 irq_ack,
    output logic [CNT_W-1:0]                     fault_count_a,
    output logic [CNT_W-1:0]                     fault_count_b,
    output logic [CNT_W-1:0]                     fault_count_c,
    output logic [5:0]                           core_state,
    output logic [2:0]                           core_faulty,
    output logic                                 any_disagreement,
    output logic                                 system_healthy,
    output logic                                 tmr_active,
    output logic                                 irq
);

    localparam int N_W = $clog2(N_VOTERS + 1);

    logic [N_W-1:0]     n_inc [N_CORES];
    logic [CNT_W-1:0]   cnt   [N_CORES];
    core_state_t        st    [N_CORES];
    logic [N_CORES-1:0] enter;
    logic               decay_tick;
    logic               disagree_now;

    always_comb begin
        for (int c = 0; c < N_CORES; c++) begin
            n_inc[c] = '0;
            for (int v = 0; v < N_VOTERS; v++)
                if (!voter_mask[v])
                    n_inc[c] = n_inc[c] + N_W'(voter_faults[FAULT_BITS_PER_VOTER*v + c]);
        end
    end

    assign disagree_now = |(voter_disagree & ~voter_mask);

    // Free-running decay timer; the tick fires on the wrap cycle.
    generate
        if (DECAY_PERIOD == 0) begin : g_no_decay
            assign decay_tick = 1'b0;
        end else begin : g_decay
            localparam int TW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
            localparam logic [TW-1:0] LAST = TW'(DECAY_PERIOD - 1);
            logic [TW-1:0] timer;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    timer <= '0;
                else if (clear || timer == LAST)
                    timer <= '0;
                else
                    timer <= timer + 1'b1;
            end

            assign decay_tick = (timer == LAST);
        end
    endgenerate

    for (genvar c = 0; c < N_CORES; c++) begin : g_core
        tmr_core_health #(
            .CNT_W          (CNT_W),
            .N_W            (N_W),
            .SUSPECT_THRESH (SUSPECT_THRESH),
            .FAULT_THRESH   (FAULT_THRESH)
        ) u_core (
            .clk          (clk),
            .rst_n        (rst_n),
            .n_inc        (n_inc[c]),
            .decay_tick   (decay_tick),
            .clear        (clear),
            .count        (cnt[c]),
            .state        (st[c]),
            .enter_faulty (enter[c])
        );
        assign core_faulty[c] = (st[c] == FAULTY);
    end

    assign fault_count_a = cnt[CORE_A];
    assign fault_count_b = cnt[CORE_B];
    assign fault_count_c = cnt[CORE_C];
    assign core_state    = {st[CORE_A], st[CORE_B], st[CORE_C]};

    logic two_faulty;
    assign two_faulty = (core_faulty[0] & core_faulty[1]) |
                        (core_faulty[0] & core_faulty[2]) |
                        (core_faulty[1] & core_faulty[2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_disagreement <= 1'b0;
            system_healthy   <= 1'b0;
            tmr_active       <= 1'b0;
            irq              <= 1'b0;
        end else begin
            any_disagreement <= disagree_now;
            system_healthy   <= !disagree_now && (core_state == '0);
            tmr_active       <= clear || !two_faulty;
            if (clear)
                irq <= 1'b0;
            else if (|enter)
                irq <= 1'b1;
            else if (irq_ack)
                irq <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tmr_health_tracker.sv
// Self-checking bench for tmr_health_tracker: directed vector table, corner
// sequences, and random traffic compared against an integer reference model.
module tb_tmr_health_tracker;

    localparam int NV   = 5;
    localparam int CW   = 4;
    localparam int SUS  = 4;
    localparam int FLT  = 8;
    localparam int DP   = 16;
    localparam int CMAX = 15;

    localparam logic [14:0] ALL_A = 15'h4924;
    localparam logic [14:0] ALL_B = 15'h2492;
    localparam logic [14:0] ALL_C = 15'h1249;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NV-1:0] voter_disagree;
    logic [3*NV-1:0] voter_faults;
    logic [NV-1:0] voter_mask;
    logic          clear;
    logic          irq_ack;
    logic [CW-1:0] fault_count_a, fault_count_b, fault_count_c;
    logic [5:0]    core_state;
    logic [2:0]    core_faulty;
    logic          any_disagreement, system_healthy, tmr_active, irq;

    always #5 clk = ~clk;

    tmr_health_tracker #(
        .N_VOTERS       (NV),
        .CNT_W          (CW),
        .SUSPECT_THRESH (SUS),
        .FAULT_THRESH   (FLT),
        .DECAY_PERIOD   (DP)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .voter_disagree   (voter_disagree),
        .voter_faults     (voter_faults),
        .voter_mask       (voter_mask),
        .clear            (clear),
        .irq_ack          (irq_ack),
        .fault_count_a    (fault_count_a),
        .fault_count_b    (fault_count_b),
        .fault_count_c    (fault_count_c),
        .core_state       (core_state),
        .core_faulty      (core_faulty),
        .any_disagreement (any_disagreement),
        .system_healthy   (system_healthy),
        .tmr_active       (tmr_active),
        .irq              (irq)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: index 2 = core A, 1 = B, 0 = C; states 0/1/2 = healthy/suspect/faulty.
    int m_cnt [3];
    int m_st  [3];
    int m_timer, m_irq, m_act, m_shl, m_dis;

    function automatic void model_reset();
        for (int c = 0; c < 3; c++) begin
            m_cnt[c] = 0;
            m_st[c]  = 0;
        end
        m_timer = 0; m_irq = 0; m_act = 0; m_shl = 0; m_dis = 0;
    endfunction

    function automatic void model_step();
        int  n [3];
        int  new_cnt [3];
        int  new_st [3];
        int  n_faulty;
        bit  tick, entered, dis_now, all_ok;
        tick = (DP != 0) && (m_timer == DP - 1);
        dis_now = 1'b0;
        for (int v = 0; v < NV; v++)
            if (!voter_mask[v] && voter_disagree[v]) dis_now = 1'b1;
        entered  = 1'b0;
        n_faulty = 0;
        all_ok   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            n[c] = 0;
            for (int v = 0; v < NV; v++)
                if (!voter_mask[v] && voter_faults[3*v + c]) n[c]++;
            if (clear)                      new_cnt[c] = 0;
            else if (n[c] > 0)              new_cnt[c] = (m_cnt[c] + n[c] > CMAX) ? CMAX : m_cnt[c] + n[c];
            else if (tick && m_cnt[c] > 0)  new_cnt[c] = m_cnt[c] - 1;
            else                            new_cnt[c] = m_cnt[c];
            if (clear)                              new_st[c] = 0;
            else if (m_st[c] == 2)                  new_st[c] = 2;
            else if (m_cnt[c] >= FLT)               new_st[c] = 2;
            else if (m_st[c] == 0 && m_cnt[c] >= SUS) new_st[c] = 1;
            else if (m_st[c] == 1 && m_cnt[c] == 0) new_st[c] = 0;
            else                                    new_st[c] = m_st[c];
            if (new_st[c] == 2 && m_st[c] != 2) entered = 1'b1;
            if (m_st[c] == 2) n_faulty++;
            if (m_st[c] != 0) all_ok = 1'b0;
        end
        if (clear)        m_irq = 0;
        else if (entered) m_irq = 1;
        else if (irq_ack) m_irq = 0;
        m_act = (clear || n_faulty < 2) ? 1 : 0;
        m_shl = (!dis_now && all_ok) ? 1 : 0;
        m_dis = dis_now ? 1 : 0;
        if (clear || m_timer == DP - 1) m_timer = 0;
        else                            m_timer = m_timer + 1;
        for (int c = 0; c < 3; c++) begin
            m_cnt[c] = new_cnt[c];
            m_st[c]  = new_st[c];
        end
    endfunction

    task automatic compare_all();
        check("count_a", fault_count_a, m_cnt[2]);
        check("count_b", fault_count_b, m_cnt[1]);
        check("count_c", fault_count_c, m_cnt[0]);
        check("core_state", core_state, m_st[2] * 16 + m_st[1] * 4 + m_st[0]);
        check("core_faulty", core_faulty,
              (m_st[2] == 2 ? 4 : 0) + (m_st[1] == 2 ? 2 : 0) + (m_st[0] == 2 ? 1 : 0));
        check("irq", irq, m_irq);
        check("tmr_active", tmr_active, m_act);
        check("system_healthy", system_healthy, m_shl);
        check("any_disagreement", any_disagreement, m_dis);
    endtask

    task automatic cycle(input logic [4:0] dis, input logic [14:0] flt, input logic [4:0] msk,
                         input logic clr, input logic ack);
        voter_disagree = dis;
        voter_faults   = flt;
        voter_mask     = msk;
        clear          = clr;
        irq_ack        = ack;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    typedef struct {
        logic [4:0]  dis;
        logic [14:0] flt;
        logic [4:0]  msk;
        int ea, eb, ec, est, eirq, eact, edis, eshl;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int span;
        tbl[0] = '{5'h00, 15'h0000, 5'h00, 0, 0, 0, 0,  0, 1, 0, 1};
        tbl[1] = '{5'h1F, ALL_A,    5'h00, 5, 0, 0, 0,  0, 1, 1, 0};
        tbl[2] = '{5'h00, 15'h0000, 5'h00, 5, 0, 0, 16, 0, 1, 0, 1};
        tbl[3] = '{5'h1F, 15'h7FFF, 5'h1F, 5, 0, 0, 16, 0, 1, 0, 0};
        tbl[4] = '{5'h00, 15'h0012, 5'h00, 5, 2, 0, 16, 0, 1, 0, 0};

        rst_n = 1'b0;
        voter_disagree = '0; voter_faults = '0; voter_mask = '0;
        clear = 1'b0; irq_ack = 1'b0;
        model_reset();
        #12;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            cycle(tbl[i].dis, tbl[i].flt, tbl[i].msk, 1'b0, 1'b0);
            check($sformatf("vec%0d_a", i),    fault_count_a,    tbl[i].ea);
            check($sformatf("vec%0d_b", i),    fault_count_b,    tbl[i].eb);
            check($sformatf("vec%0d_c", i),    fault_count_c,    tbl[i].ec);
            check($sformatf("vec%0d_st", i),   core_state,       tbl[i].est);
            check($sformatf("vec%0d_irq", i),  irq,              tbl[i].eirq);
            check($sformatf("vec%0d_act", i),  tmr_active,       tbl[i].eact);
            check($sformatf("vec%0d_dis", i),  any_disagreement, tbl[i].edis);
            check($sformatf("vec%0d_shl", i),  system_healthy,   tbl[i].eshl);
        end

        // Saturation, FAULTY entry, irq set and ack.
        cycle(5'h00, 15'h0, 5'h00, 1'b1, 1'b0);
        cycle(5'h1F, ALL_A, 5'h00, 1'b0, 1'b0);
        check("sat_step1", fault_count_a, 5);
        cycle(5'h1F, ALL_A, 5'h00, 1'b0, 1'b0);
        check("sat_step2", fault_count_a, 10);
        cycle(5'h1F, ALL_A, 5'h00, 1'b0, 1'b0);
        check("sat_step3", fault_count_a, 15);
        cycle(5'h1F, ALL_A, 5'h00, 1'b0, 1'b0);
        check("sat_nowrap", fault_count_a, 15);
        check("a_faulty", core_state[5:4], 2);
        check("irq_set", irq, 1);
        cycle(5'h00, 15'h0, 5'h00, 1'b0, 1'b1);
        check("irq_ack_clears", irq, 0);

        // Leaky-bucket decay of core B from 4 down to 0.
        cycle(5'h00, 15'h0, 5'h00, 1'b1, 1'b0);
        cycle(5'h00, 15'h0492, 5'h00, 1'b0, 1'b0);
        check("b_load", fault_count_b, 4);
        span = 0;
        for (int i = 1; i <= 80; i++) begin
            cycle(5'h00, 15'h0, 5'h00, 1'b0, 1'b0);
            if (fault_count_b == 0) begin
                span = i;
                break;
            end
        end
        check("decay_span", span, 63);
        check("b_suspect_at_zero", core_state[3:2], 1);
        cycle(5'h00, 15'h0, 5'h00, 1'b0, 1'b0);
        check("b_healthy_after_zero", core_state[3:2], 0);

        // All voters masked: no increments.
        cycle(5'h1F, 15'h7FFF, 5'h1F, 1'b0, 1'b0);
        check("masked_a", fault_count_a, 0);
        check("masked_dis", any_disagreement, 0);

        // Two faulty cores drop tmr_active; clear restores everything.
        cycle(5'h00, 15'h0, 5'h00, 1'b1, 1'b0);
        cycle(5'h00, ALL_A | ALL_B, 5'h00, 1'b0, 1'b0);
        cycle(5'h00, ALL_A | ALL_B, 5'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(5'h00, 15'h0, 5'h00, 1'b0, 1'b0);
        check("tmr_drop", tmr_active, 0);
        check("ab_faulty", core_faulty, 3'b110);
        cycle(5'h00, 15'h0, 5'h00, 1'b1, 1'b0);
        check("clr_a", fault_count_a, 0);
        check("clr_state", core_state, 0);
        check("clr_irq", irq, 0);
        check("clr_act", tmr_active, 1);

        // irq_ack coinciding with core C entering FAULTY: set wins.
        cycle(5'h00, ALL_C, 5'h00, 1'b0, 1'b0);
        cycle(5'h00, ALL_C, 5'h00, 1'b0, 1'b0);
        cycle(5'h00, 15'h0, 5'h00, 1'b0, 1'b1);
        check("c_enter_faulty", core_state[1:0], 2);
        check("irq_set_beats_ack", irq, 1);

        // Random traffic against the model.
        cycle(5'h00, 15'h0, 5'h00, 1'b1, 1'b0);
        for (int i = 0; i < 400; i++) begin
            cycle(5'($urandom & $urandom),
                  15'($urandom & $urandom & $urandom),
                  5'($urandom & $urandom & $urandom),
                  ($urandom_range(0, 60) == 0),
                  ($urandom_range(0, 7) == 0));
        end

        // Asynchronous reset mid-increment.
        cycle(5'h1F, ALL_A, 5'h00, 1'b0, 1'b0);
        cycle(5'h1F, ALL_A, 5'h00, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        voter_disagree = '0; voter_faults = '0; voter_mask = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(5'h00, 15'h0, 5'h00, 1'b0, 1'b0);
        check("act_after_reset", tmr_active, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tmr_health_tracker.md
Name: tmr_health_tracker

Overview:
Parametrised successor to the TMR fault monitor. Aggregates disagreement and per-core fault flags from N_VOTERS voters, with per-voter masking. Keeps saturating, leaky-bucket fault counters per core and runs a per-core HEALTHY/SUSPECT/FAULTY state machine. Raises a sticky interrupt when a core becomes FAULTY, and drops tmr_active once TMR can no longer mask faults. Sits beside the voters and feeds the system status/CSR block.

Parameters:
N_VOTERS, 5, number of voters feeding the block (1..15)
CNT_W, 16, width of each per-core fault counter
SUSPECT_THRESH, 16, counter value at or above which a core is SUSPECT
FAULT_THRESH, 100, counter value at or above which a core is FAULTY; requires SUSPECT_THRESH < FAULT_THRESH < 2^CNT_W-1
DECAY_PERIOD, 1024, cycles between leaky-bucket decrements; 0 disables decay

Ports:
clk  in  1  clock (rising edge)
rst_n  in  1  asynchronous active-low reset
voter_disagree  in  N_VOTERS  bit i = voter i reports disagreement
voter_faults  in  3*N_VOTERS  voter i at [3i+2:3i] = {A,B,C}
voter_mask  in  N_VOTERS  1 = ignore voter i (disagree and faults)
clear  in  1  synchronous pulse: reset counters, states, decay timer, irq
irq_ack  in  1  clears irq
fault_count_a / _b / _c  out  CNT_W each  per-core counters
core_state  out  6  {A[5:4],B[3:2],C[1:0]}; 00 HEALTHY, 01 SUSPECT, 10 FAULTY
core_faulty  out  3  {A,B,C}; 1 when state == FAULTY
any_disagreement  out  1  registered OR of unmasked voter_disagree
system_healthy  out  1  registered health summary
tmr_active  out  1  TMR still able to mask a faulty core
irq  out  1  sticky fault interrupt

Behaviour:
- Reset (rst_n low, asynchronous): all counters 0, all states HEALTHY, core_faulty 0, any_disagreement 0, system_healthy 0, tmr_active 0, irq 0, decay timer 0.
- Per-cycle increment n_x = popcount of unmasked fault bits for core x; width $clog2(N_VOTERS+1).
- Counter update, by priority:
  - clear: counter → 0.
  - n_x > 0: count ← min(count + n_x, 2^CNT_W-1). Saturating, never wraps; compute with a CNT_W+1 sum.
  - Decay tick and count ≠ 0: count ← count-1. A decay tick coinciding with n_x > 0 is skipped for that core only.
- Decay timer: counts 0..DECAY_PERIOD-1 and asserts a tick on the wrap cycle. It is free-running and never stops at saturation; clear restarts it at 0. With DECAY_PERIOD = 0 there are no ticks.
- FSM per core, evaluated on the registered count:
  - HEALTHY → SUSPECT when count ≥ SUSPECT_THRESH.
  - HEALTHY or SUSPECT → FAULTY when count ≥ FAULT_THRESH. HEALTHY may jump straight to FAULTY.
  - SUSPECT → HEALTHY when count == 0.
  - FAULTY is sticky until clear or reset.
- Latency: fault input at edge t → counter at t+1 → state and core_faulty at t+2.
- irq:
  - Set on the edge where any core enters FAULTY.
  - Cleared by irq_ack.
  - Set wins over a simultaneous ack.
  - clear forces irq to 0.
- any_disagreement = registered OR of unmasked voter_disagree (1-cycle latency).
- system_healthy = registered (no unmasked disagreement AND all three states HEALTHY).
- tmr_active:
  - 0 in reset; 1 from the first clock after reset deassertion.
  - Falls to 0 on the cycle after ≥2 cores are FAULTY.
  - Returns to 1 after clear.
- All voters masked: no increments occur, but decay still applies.
- Reset asserted mid-operation has immediate effect regardless of clock.

Decomposition:
- Package tmr_pkg holds:
  - core_state_t enum (HEALTHY = 2'b00, SUSPECT = 2'b01, FAULTY = 2'b10)
  - core index constants CORE_A = 2, CORE_B = 1, CORE_C = 0
  - fault-bit layout constants
- Sub-module tmr_core_health, instantiated three times. It contains one counter, the saturation logic, the decay consumer and the FSM; inputs are n_x, decay_tick and clear.
- The top level owns the popcounts, masking, decay timer, irq and status logic.

Test Plan:
- Bench parameters: SUSPECT_THRESH = 4, FAULT_THRESH = 8, DECAY_PERIOD = 16, CNT_W = 4, N_VOTERS = 5.
- Single cycle with all 5 voters flagging A → fault_count_a = 5 at t+1; core_state A = SUSPECT at t+2; B/C unchanged.
- A flagged by 5 voters for 3 consecutive cycles → count saturates at 15 with no wrap. State reaches FAULTY, irq = 1; irq_ack with no new fault clears irq.
- Count_b = 4 (SUSPECT) with no further faults → one decrement every 16 cycles. State returns to HEALTHY the cycle after count reaches 0.
- voter_mask = 5'b11111 with voter_faults = all ones → counters stay 0 and any_disagreement = 0.
- A and B driven to FAULTY → tmr_active = 0. A clear pulse → counters 0, states HEALTHY, irq 0, tmr_active = 1.
- Corner cases: irq_ack on the same cycle as core C entering FAULTY → irq = 1. rst_n asserted mid-increment → all outputs reset immediately.
